// File: rtl/pdm_decimator_pkg.sv
// Shared audio definitions for the microphone capture path.
//   PCM_W        : default PCM sample width
//   SYS_CLK_HZ   : system clock frequency (clock_i)
//   PDM_CLK_HZ   : microphone bit clock produced by the divider
//   PDM_CLK_DIV  : system clocks per microphone clock period
//   dec_state_e  : decimator FSM encoding
package pdm_decimator_pkg;

  localparam int PCM_W       = 7;
  localparam int SYS_CLK_HZ  = 100_000_000;
  localparam int PDM_CLK_HZ  = 1_000_000;
  localparam int PDM_CLK_DIV = SYS_CLK_HZ / PDM_CLK_HZ;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } dec_state_e;

endpackage

// File: rtl/pdm_edge_sync.sv
// Front end of the PDM capture: brings the asynchronous microphone data into
// the clock_i domain and finds rising edges of the divided microphone clock.
// Ports:
//   clock_i    in  : system clock
//   reset_i    in  : synchronous active-high reset
//   pdm_clk_i  in  : divided microphone clock (already in the clock_i domain)
//   pdm_data_i in  : microphone data, asynchronous
//   rise       out : high for the one cycle where pdm_clk_i has just gone high
//   pdm_bit    out : synchronized microphone data
module pdm_edge_sync
  import pdm_decimator_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic pdm_clk_i,
  input  logic pdm_data_i,
  output logic rise,
  output logic pdm_bit
);

  logic data_meta;
  logic data_sync;
  logic pdm_clk_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      data_meta <= 1'b0;
      data_sync <= 1'b0;
      pdm_clk_q <= 1'b0;
    end else begin
      data_meta <= pdm_data_i;
      data_sync <= data_meta;
      pdm_clk_q <= pdm_clk_i;
    end
  end

  // pdm_clk_i is a register output in this domain, so no synchronizer here.
  assign rise    = pdm_clk_i & ~pdm_clk_q;
  assign pdm_bit = data_sync;

endmodule

// File: rtl/pdm_decimator.sv
// PDM to PCM decimator: counts ones over DECIM microphone bits and offers
// each count as a PCM sample through a single-entry valid/ready register.
// Ports:
//   clock_i        in  : system clock (100 MHz)
//   reset_i        in  : synchronous active-high reset
//   enable_i       in  : capture enable
//   pdm_clk_i      in  : divided microphone clock
//   pdm_data_i     in  : microphone data, asynchronous
//   sample_o       out : PCM sample, number of ones in the window
//   sample_valid_o out : sample_o holds an unconsumed sample
//   sample_ready_i in  : consumer takes the sample
//   overrun_o      out : sticky, a finished sample was dropped
//   active_o       out : FSM is in RUN
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | disabled; counters held at 0
// ST_WARMUP | windows counted and discarded while the microphone settles
// ST_RUN    | every completed window is offered at the output
module pdm_decimator
  import pdm_decimator_pkg::*;
#(
  parameter int DECIM        = 64,
  parameter int SAMPLE_W     = PCM_W,
  parameter int SKIP_WINDOWS = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                pdm_clk_i,
  input  logic                pdm_data_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                overrun_o,
  output logic                active_o
);

  localparam logic [7:0] LAST_BIT  = 8'(DECIM - 1);
  localparam logic [3:0] LAST_SKIP = 4'(SKIP_WINDOWS - 1);

  dec_state_e state_q, state_d;

  logic                rise;
  logic                pdm_bit;
  logic [7:0]          bit_cnt_q;
  logic [SAMPLE_W-1:0] acc_q;
  logic [3:0]          win_cnt_q;
  logic                bit_take;
  logic                win_done;
  logic                warm_last;
  logic                offer;
  logic [SAMPLE_W-1:0] win_sum;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                overrun_q;

  pdm_edge_sync u_edge_sync (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .pdm_clk_i  (pdm_clk_i),
    .pdm_data_i (pdm_data_i),
    .rise       (rise),
    .pdm_bit    (pdm_bit)
  );

  // A rise seen while enable_i is low, or while still in IDLE, is ignored.
  assign bit_take  = enable_i & rise & (state_q != ST_IDLE);
  assign win_done  = bit_take & (bit_cnt_q == LAST_BIT);
  assign win_sum   = acc_q + SAMPLE_W'(pdm_bit);
  assign warm_last = win_done & (state_q == ST_WARMUP) & (win_cnt_q == LAST_SKIP);
  assign offer     = win_done & (state_q == ST_RUN);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = (SKIP_WINDOWS == 0) ? ST_RUN : ST_WARMUP;
        ST_WARMUP: if (warm_last) state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || !enable_i || state_q == ST_IDLE) begin
      bit_cnt_q <= '0;
      acc_q     <= '0;
      win_cnt_q <= '0;
    end else if (bit_take) begin
      if (win_done) begin
        bit_cnt_q <= '0;
        acc_q     <= '0;
        if (state_q == ST_WARMUP) win_cnt_q <= win_cnt_q + 4'd1;
      end else begin
        bit_cnt_q <= bit_cnt_q + 8'd1;
        acc_q     <= win_sum;
      end
    end
  end

  // Single-entry output register. A consumer ready in the completion cycle
  // frees the slot in time for the new sample, so valid never drops.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (offer) begin
      if (!valid_q || sample_ready_i) begin
        sample_q <= win_sum;
        valid_q  <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (sample_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign active_o       = (state_q == ST_RUN);

endmodule

// File: tb/tb_pdm_decimator.sv
module tb_pdm_decimator;

  localparam int DECIM    = 8;
  localparam int SAMPLE_W = 4;
  localparam int SKIP     = 1;

  logic                clock_i = 1'b0;
  logic                reset_i = 1'b1;
  logic                enable_i = 1'b0;
  logic                pdm_clk_i = 1'b0;
  logic                pdm_data_i = 1'b0;
  logic                sample_ready_i = 1'b0;
  logic [SAMPLE_W-1:0] sample_o;
  logic                sample_valid_o;
  logic                overrun_o;
  logic                active_o;

  always #5 clock_i = ~clock_i;

  pdm_decimator #(
    .DECIM        (DECIM),
    .SAMPLE_W     (SAMPLE_W),
    .SKIP_WINDOWS (SKIP)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .pdm_clk_i      (pdm_clk_i),
    .pdm_data_i     (pdm_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .overrun_o      (overrun_o),
    .active_o       (active_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  // Reference model: session mode (0 idle, 1 warm-up, 2 run), bits of the
  // current window, windows discarded so far, and the output slot occupancy.
  int exp_q[$];
  int m_bits[$];
  int m_mode    = 0;
  int m_win     = 0;
  bit m_valid   = 0;
  bit m_overrun = 0;
  bit m_clk_q   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit rst, input bit en, input bit pc,
                            input bit dat, input bit rdy);
    bit r;
    bit done;
    int res;
    r       = pc && !m_clk_q;
    m_clk_q = rst ? 1'b0 : pc;
    done    = 0;
    res     = 0;
    if (rst) begin
      m_mode = 0; m_win = 0; m_bits.delete();
      m_valid = 0; m_overrun = 0; exp_q.delete();
      return;
    end
    if (!en) begin
      m_mode = 0; m_win = 0; m_bits.delete();
    end else if (m_mode == 0) begin
      m_mode = (SKIP == 0) ? 2 : 1;
    end else if (r) begin
      m_bits.push_back(int'(dat));
      if (m_bits.size() == DECIM) begin
        res = m_bits.sum();
        m_bits.delete();
        if (m_mode == 1) begin
          m_win++;
          if (m_win == SKIP) m_mode = 2;
        end else begin
          done = 1;
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        exp_q.push_back(res);
        m_valid = 1;
      end else begin
        m_overrun = 1;
      end
    end else if (rdy) begin
      m_valid = 0;
    end
  endtask

  // Inputs applied here are seen by the DUT at the next posedge; the model
  // then advances with exactly the same inputs.
  task automatic tick(input bit rst, input bit en, input bit pc,
                      input bit dat, input bit rdy);
    reset_i = rst; enable_i = en; pdm_clk_i = pc;
    pdm_data_i = dat; sample_ready_i = rdy;
    @(posedge clock_i);
    #1;
    model_step(rst, en, pc, dat, rdy);
  endtask

  // ready modes: 0 never, 1 always, 2 random, 3 only in the rise cycle
  function automatic bit pick_rdy(input int mode, input bit at_rise);
    case (mode)
      1:       return 1'b1;
      2:       return bit'($urandom_range(0, 1));
      3:       return at_rise;
      default: return 1'b0;
    endcase
  endfunction

  // One microphone clock period; data and enable change only at the falling
  // edge, well before the next rise.
  task automatic pdm_period(input bit dat, input int rmode, input bit en);
    int lo = $urandom_range(3, 5);
    int hi = $urandom_range(2, 5);
    for (int i = 0; i < lo; i++) tick(0, en, 0, dat, pick_rdy(rmode, 1'b0));
    for (int i = 0; i < hi; i++) tick(0, en, 1, dat, pick_rdy(rmode, i == 0));
  endtask

  task automatic window(input logic [7:0] pat, input int rmode, input int rmode_last);
    for (int i = 0; i < DECIM; i++)
      pdm_period(pat[i], (i == DECIM - 1) ? rmode_last : rmode, 1'b1);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clock_i);
      if (mon_en) begin
        check("valid", int'(sample_valid_o), int'(m_valid));
        check("overrun", int'(overrun_o), int'(m_overrun));
        check("active", int'(active_o), int'(m_mode == 2));
        if (sample_valid_o && exp_q.size() > 0)
          check("held_sample", int'(sample_o), exp_q[0]);
        if (sample_valid_o && sample_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL handshake: sample %0d taken, none expected at %0t", sample_o, $time);
          end else begin
            check("taken_sample", int'(sample_o), exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit en;
    int dens;
    int rmode;

    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
    check("reset_sample", int'(sample_o), 0);
    mon_en = 1;
    tick(0, 0, 0, 0, 0);

    // warm-up window discarded, then 1,0,1,1,0,0,1,1 -> 5
    window(8'hFF, 1, 1);
    window(8'b1100_1101, 1, 1);
    // 3 then 6 with no consumer -> 3 held, overrun
    window(8'b0000_0111, 0, 0);
    window(8'b0011_1111, 0, 0);
    // ready only in the completion cycle of a 7 window
    window(8'b0111_1111, 0, 3);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 1);

    // enable dropped after 5 bits, then re-enabled
    for (int i = 0; i < 5; i++) pdm_period(1'b1, 1, 1'b1);
    for (int i = 0; i < 3; i++) pdm_period(1'b1, 1, 1'b0);
    window(8'hFF, 1, 1);
    window(8'hFF, 1, 1);

    // reset mid-window while a sample is held and overrun is set
    window(8'h0F, 0, 0);
    window(8'h03, 0, 0);
    for (int i = 0; i < 3; i++) pdm_period(1'b1, 0, 1'b1);
    tick(1, 0, 0, 0, 0);
    check("mid_reset_sample", int'(sample_o), 0);
    for (int i = 0; i < 2; i++) pdm_period(1'b1, 0, 1'b0);

    // randomized traffic
    en = 1;
    dens = 4;
    rmode = 2;
    for (int p = 0; p < 1200; p++) begin
      if (p % DECIM == 0) begin
        dens  = $urandom_range(0, 8);
        rmode = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 299) == 0) begin
        tick(1, 0, 0, 0, 0);
        en = 0;
      end
      if (en && $urandom_range(0, 39) == 0) en = 0;
      else if (!en && $urandom_range(0, 1) == 0) en = 1;
      pdm_period(bit'($urandom_range(0, 7) < 32'(dens)), rmode, en);
    end

    for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 1);
    check("drained", exp_q.size(), 0);
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
